mem_stage: RTL

- MEM stage of the 32I pipeline. It sits directly downstream of the EX stage and consumes its alu_result (the effective address) and the forwarded store operand.
- It runs byte, half and word loads and stores against a req/ack data-memory port, including byte-lane steering and load sign/zero extension.
- It delivers a registered result to write-back. It back-pressures EX via in_ready while a memory access is outstanding.

---
 rtl/mem_stage.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I MEM stage driving a req/ack data-memory port.
// Optional ack watchdog is built in when MEM_TIMEOUT_EN is defined.

module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_store_data,
   input  logic [4:0]  i_rd,
   input  logic        i_reg_write,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_be,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_wb_valid,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_wb_rd,
   output logic        o_wb_reg_write,
   output logic        o_wb_misalign,
   output logic        o_wb_bus_err
);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic [2:0]  r_funct3;
   logic [1:0]  r_lane;
   logic        r_store;

   logic        r_wb_valid;
   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_rd;
   logic        r_wb_reg_write;
   logic        r_wb_misalign;
   logic        r_wb_bus_err;

   logic        w_accept;
   logic        w_is_mem;
   logic        w_legal;
   logic        w_aligned;
   logic        w_violation;
   logic        w_start;
   logic        w_done;
   logic        w_timeout;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_rbyte;
   logic [15:0] w_rhalf;
   logic [31:0] w_load;

   // Decode the incoming access: legality, alignment and start condition.
   always_comb begin
      w_accept  = i_in_valid && (r_state == S_IDLE);
      w_is_mem  = i_mem_read || i_mem_write;
      w_lane    = i_alu_result[1:0];
      w_legal   = 1'b0;
      w_aligned = 1'b1;
      if (i_mem_write) begin
         w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                   (i_funct3 == 3'b010);
      end else begin
         w_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                   (i_funct3 == 3'b010) || (i_funct3 == 3'b100) ||
                   (i_funct3 == 3'b101);
      end
      case (i_funct3[1:0])
         2'b01:   w_aligned = ~w_lane[0];
         2'b10:   w_aligned = (w_lane == 2'b00);
         default: w_aligned = 1'b1;
      endcase
      w_violation = w_is_mem && !(w_legal && w_aligned);
      w_start     = w_accept && w_is_mem && !w_violation;
   end

   // Store lane steering; loads always read the full word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_store_data;
      if (i_mem_write) begin
         case (i_funct3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << w_lane;
               w_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
               w_be    = 4'b0011 << w_lane;
               w_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = i_store_data;
            end
         endcase
      end
   end

   // Pick the addressed byte/half from the returned word and extend it.
   always_comb begin
      w_rbyte = i_dmem_rdata[{r_lane, 3'b000} +: 8];
      w_rhalf = r_lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_load = {{24{w_rbyte[7]}}, w_rbyte};
         3'b100:  w_load = {24'd0, w_rbyte};
         3'b001:  w_load = {{16{w_rhalf[15]}}, w_rhalf};
         3'b101:  w_load = {16'd0, w_rhalf};
         default: w_load = i_dmem_rdata;
      endcase
   end

   assign w_done = (r_state == S_BUSY) && i_dmem_ack;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned LOG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CW    = (LOG_W > 8) ? LOG_W : 8;

   logic [CW-1:0] r_cnt;

   // r_cnt holds BUSY cycles already spent without ack; the abort fires
   // on the edge that would make it reach TIMEOUT_CYCLES.
   assign w_timeout = (r_state == S_BUSY) && !i_dmem_ack &&
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog count of unacknowledged BUSY cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_start) begin
         r_cnt <= '0;
      end else if ((r_state == S_BUSY) && !i_dmem_ack) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end
`else
   logic w_unused_timeout;

   // Without the watchdog the parameter has no effect.
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and ready.
   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = (r_state == S_IDLE);
      unique case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_done || w_timeout) begin
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // Memory request and write-back registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_req          <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_be           <= '0;
         r_wdata        <= '0;
         r_rd           <= '0;
         r_reg_write    <= 1'b0;
         r_funct3       <= '0;
         r_lane         <= '0;
         r_store        <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_wb_data      <= '0;
         r_wb_rd        <= '0;
         r_wb_reg_write <= 1'b0;
         r_wb_misalign  <= 1'b0;
         r_wb_bus_err   <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         if (w_accept && !w_is_mem) begin
            r_wb_valid     <= 1'b1;
            r_wb_data      <= i_alu_result;
            r_wb_rd        <= i_rd;
            r_wb_reg_write <= i_reg_write;
            r_wb_misalign  <= 1'b0;
            r_wb_bus_err   <= 1'b0;
         end else if (w_accept && w_violation) begin
            r_wb_valid     <= 1'b1;
            r_wb_data      <= i_alu_result;
            r_wb_rd        <= i_rd;
            r_wb_reg_write <= 1'b0;
            r_wb_misalign  <= 1'b1;
            r_wb_bus_err   <= 1'b0;
         end else if (w_start) begin
            r_req       <= 1'b1;
            r_we        <= i_mem_write;
            r_addr      <= {i_alu_result[31:2], 2'b00};
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_rd        <= i_rd;
            r_reg_write <= i_reg_write;
            r_funct3    <= i_funct3;
            r_lane      <= w_lane;
            r_store     <= i_mem_write;
         end else if (w_done) begin
            r_req          <= 1'b0;
            r_wb_valid     <= 1'b1;
            r_wb_data      <= r_store ? 32'd0 : w_load;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= r_store ? 1'b0 : r_reg_write;
            r_wb_misalign  <= 1'b0;
            r_wb_bus_err   <= 1'b0;
         end else if (w_timeout) begin
            r_req          <= 1'b0;
            r_wb_valid     <= 1'b1;
            r_wb_data      <= 32'd0;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= 1'b0;
            r_wb_misalign  <= 1'b0;
            r_wb_bus_err   <= 1'b1;
         end
      end
   end

   assign o_dmem_req     = r_req;
   assign o_dmem_we      = r_we;
   assign o_dmem_addr    = r_addr;
   assign o_dmem_be      = r_be;
   assign o_dmem_wdata   = r_wdata;
   assign o_wb_valid     = r_wb_valid;
   assign o_wb_data      = r_wb_data;
   assign o_wb_rd        = r_wb_rd;
   assign o_wb_reg_write = r_wb_reg_write;
   assign o_wb_misalign  = r_wb_misalign;
   assign o_wb_bus_err   = r_wb_bus_err;

endmodule
